// File: rtl/qvc_pkg.sv
// Shared fixed-point types, FSM state encoding and the positive saturation helper
// used by the VQC read-out blocks.
package qvc_pkg;

  localparam int QN    = 16;
  localparam int QFRAC = 14;

  typedef logic signed [QN-1:0] amp_t;

  typedef struct packed {
    amp_t re;
    amp_t im;
  } cplx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Returns {saturated, value}; clamps a non-negative value to 2^(n-1)-1.
  function automatic logic [64:0] sat_pos(input logic [63:0] v, input int n);
    logic [63:0] mx;
    mx = (64'd1 << (n - 1)) - 64'd1;
    if (v > mx) return {1'b1, mx};
    else        return {1'b0, v};
  endfunction

endpackage

// File: rtl/complex_mag_sq.sv
// Registered |a|^2 of a signed fixed-point complex value, one cycle latency.
// Result is (re*re + im*im) >>> FRAC on 2N bits, truncated, N+2 bits wide.
module complex_mag_sq
  import qvc_pkg::*;
#(
  parameter int N    = QN,
  parameter int FRAC = QFRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [N-1:0] re,
  input  logic signed [N-1:0] im,
  output logic        [N+1:0] sq
);

  localparam int SQW = N + 2;

  logic signed [2*N-1:0] re_x;
  logic signed [2*N-1:0] im_x;
  logic signed [2*N-1:0] p_re;
  logic signed [2*N-1:0] p_im;
  logic        [2*N-1:0] sum;

  assign re_x = {{N{re[N-1]}}, re};
  assign im_x = {{N{im[N-1]}}, im};
  assign p_re = re_x * re_x;
  assign p_im = im_x * im_x;
  // Each square is at most 2^(2N-2), so the unsigned sum cannot wrap on 2N bits.
  assign sum  = $unsigned(p_re) + $unsigned(p_im);

  always_ff @(posedge clk) begin
    if (rst) sq <= '0;
    else     sq <= SQW'(sum >> FRAC);
  end

endmodule

// File: rtl/marginal_prob_stream.sv
// Streams a D1*D2 joint amplitude vector and reduces it to the subsystem-1 marginals.
// Define MARG2_EN to also produce the subsystem-2 marginals on out_prob2.
//
// state   | meaning
// S_IDLE  | waiting for the first beat of a frame
// S_ACC   | accepting beats, accumulating |psi|^2 per bin
// S_DRAIN | all beats taken, waiting for the 2-stage pipe to empty
// S_OUT   | result held on out_prob*, waiting for out_ready
module marginal_prob_stream
  import qvc_pkg::*;
#(
  parameter int N    = QN,
  parameter int FRAC = QFRAC,
  parameter int D1   = 2,
  parameter int D2   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_re,
  input  logic [N-1:0]         in_im,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [D1-1:0][N-1:0] out_prob1,
`ifdef MARG2_EN
  output logic [D2-1:0][N-1:0] out_prob2,
`endif
  output logic                 out_ovr,
  output logic                 out_err
);

  localparam int SQW = N + 2;
  localparam int B1W = (D1 > 1) ? $clog2(D1) : 1;
  localparam int B2W = (D2 > 1) ? $clog2(D2) : 1;
  localparam int AW1 = SQW + $clog2(D2);
  localparam logic [B1W-1:0] I_MAX = B1W'(D1 - 1);
  localparam logic [B2W-1:0] J_MAX = B2W'(D2 - 1);

  state_t         state;
  logic [B1W-1:0] i_cnt;
  logic [B2W-1:0] j_cnt;
  logic [B1W-1:0] bin1_q;
  logic           v1;
  logic           v2;
  logic           err_r;
  logic           accept;
  logic           beat_final;
  logic [SQW-1:0] sq;
  logic [AW1-1:0] acc1 [D1];

  logic [64:0]          sat1_r [D1];
  logic [D1-1:0][N-1:0] sat1;
  logic [D1-1:0]        ovr1;
  logic                 ovr_c;

  assign accept     = in_valid & in_ready;
  assign beat_final = (i_cnt == I_MAX) && (j_cnt == J_MAX);

  complex_mag_sq #(
    .N    (N),
    .FRAC (FRAC)
  ) u_mag_sq (
    .clk (clk),
    .rst (rst),
    .re  (in_re),
    .im  (in_im),
    .sq  (sq)
  );

  for (genvar k = 0; k < D1; k++) begin : g_sat1
    assign sat1_r[k] = sat_pos(64'(acc1[k]), N);
    assign sat1[k]   = N'(sat1_r[k]);
    assign ovr1[k]   = sat1_r[k][64];
  end

`ifdef MARG2_EN
  localparam int AW2 = SQW + $clog2(D1);

  logic [B2W-1:0]       bin2_q;
  logic [AW2-1:0]       acc2 [D2];
  logic [64:0]          sat2_r [D2];
  logic [D2-1:0][N-1:0] sat2;
  logic [D2-1:0]        ovr2;

  for (genvar k = 0; k < D2; k++) begin : g_sat2
    assign sat2_r[k] = sat_pos(64'(acc2[k]), N);
    assign sat2[k]   = N'(sat2_r[k]);
    assign ovr2[k]   = sat2_r[k][64];
  end

  assign ovr_c = (|ovr1) | (|ovr2);
`else
  assign ovr_c = |ovr1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_prob1 <= '0;
      out_ovr   <= 1'b0;
      out_err   <= 1'b0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      bin1_q    <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      err_r     <= 1'b0;
      for (int k = 0; k < D1; k++) acc1[k] <= '0;
`ifdef MARG2_EN
      out_prob2 <= '0;
      bin2_q    <= '0;
      for (int k = 0; k < D2; k++) acc2[k] <= '0;
`endif
    end else begin
      // Bin indices travel alongside the squared magnitude through stage 1.
      v1 <= accept;
      v2 <= v1;

      if (accept) begin
        bin1_q <= i_cnt;
`ifdef MARG2_EN
        bin2_q <= j_cnt;
`endif
        if (in_last != beat_final) err_r <= 1'b1;
        if (j_cnt == J_MAX) begin
          j_cnt <= '0;
          i_cnt <= (i_cnt == I_MAX) ? '0 : i_cnt + 1'b1;
        end else begin
          j_cnt <= j_cnt + 1'b1;
        end
      end

      if (v1) begin
        acc1[bin1_q] <= acc1[bin1_q] + AW1'(sq);
`ifdef MARG2_EN
        acc2[bin2_q] <= acc2[bin2_q] + AW2'(sq);
`endif
      end

      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (beat_final) begin
              state    <= S_DRAIN;
              in_ready <= 1'b0;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (accept && beat_final) begin
            state    <= S_DRAIN;
            in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!v1 && !v2) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_prob1 <= sat1;
            out_ovr   <= ovr_c;
            out_err   <= err_r;
`ifdef MARG2_EN
            out_prob2 <= sat2;
`endif
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            err_r     <= 1'b0;
            for (int k = 0; k < D1; k++) acc1[k] <= '0;
`ifdef MARG2_EN
            for (int k = 0; k < D2; k++) acc2[k] <= '0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_marginal_prob_stream.sv
// Directed self-checking bench for marginal_prob_stream (N=16, FRAC=14, D1=D2=2).
module tb_marginal_prob_stream;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_re = '0;
  logic [15:0]      in_im = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0][15:0] out_prob1;
`ifdef MARG2_EN
  logic [1:0][15:0] out_prob2;
`endif
  logic             out_ovr;
  logic             out_err;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   vre [4];
  int   vim [4];
  logic vlast [4];

  always #5 clk = ~clk;

  marginal_prob_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prob1 (out_prob1),
`ifdef MARG2_EN
    .out_prob2 (out_prob2),
`endif
    .out_ovr   (out_ovr),
    .out_err   (out_err)
  );

  // Drives beats first..last_idx from vre/vim/vlast, each on its own accept edge.
  task automatic send_frame(input int first, input int last_idx);
    int guard;
    for (int b = first; b <= last_idx; b++) begin
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        tests_run++;
        tests_failed++;
        $display("FAIL send_ready_timeout beat %0d in_ready stayed 0", b);
      end
      in_valid = 1'b1;
      in_re    = 16'(vre[b]);
      in_im    = 16'(vim[b]);
      in_last  = vlast[b];
      @(posedge clk);
    end
  endtask

  // Called right after the last accept edge; returns cycles until out_valid seen.
  task automatic wait_result(output int lat);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_prob1 !== 32'd0) begin tests_failed++; $display("FAIL reset_prob1 got %h want 0", out_prob1); end
    tests_run++;
    if ({out_ovr, out_err} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags got %b want 00", {out_ovr, out_err}); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basis00();
    int lat;
    vre = '{16384, 0, 0, 0}; vim = '{0, 0, 0, 0}; vlast = '{0, 0, 0, 1};
    send_frame(0, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL basis00_latency got %0d want 3", lat); end
    tests_run++;
    if (out_prob1[0] !== 16'd16384) begin tests_failed++; $display("FAIL basis00_p0 got %0d want 16384", out_prob1[0]); end
    tests_run++;
    if (out_prob1[1] !== 16'd0) begin tests_failed++; $display("FAIL basis00_p1 got %0d want 0", out_prob1[1]); end
    tests_run++;
    if ({out_ovr, out_err} !== 2'b00) begin tests_failed++; $display("FAIL basis00_flags got %b want 00", {out_ovr, out_err}); end
    consume();
  endtask

  task automatic test_uniform();
    int lat;
    vre = '{8192, 8192, 8192, 8192}; vim = '{0, 0, 0, 0}; vlast = '{0, 0, 0, 1};
    send_frame(0, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL uniform_latency got %0d want 3", lat); end
    tests_run++;
    if (out_prob1 !== {16'd8192, 16'd8192}) begin tests_failed++; $display("FAIL uniform_p1 got %h want 20002000", out_prob1); end
`ifdef MARG2_EN
    tests_run++;
    if (out_prob2 !== {16'd8192, 16'd8192}) begin tests_failed++; $display("FAIL uniform_p2 got %h want 20002000", out_prob2); end
`endif
    tests_run++;
    if ({out_ovr, out_err} !== 2'b00) begin tests_failed++; $display("FAIL uniform_flags got %b want 00", {out_ovr, out_err}); end
    consume();
  endtask

  task automatic test_phase();
    int lat;
    vre = '{0, -8192, 5793, 0}; vim = '{8192, 0, 5793, 0}; vlast = '{0, 0, 0, 1};
    send_frame(0, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL phase_latency got %0d want 3", lat); end
    tests_run++;
    if (out_prob1[0] !== 16'd8192) begin tests_failed++; $display("FAIL phase_p0 got %0d want 8192", out_prob1[0]); end
    tests_run++;
    if (!(out_prob1[1] >= 16'd4094 && out_prob1[1] <= 16'd4096)) begin
      tests_failed++; $display("FAIL phase_p1 got %0d want 4095 +/-1", out_prob1[1]);
    end
`ifdef MARG2_EN
    tests_run++;
    if (out_prob2[0] !== 16'd8192) begin tests_failed++; $display("FAIL phase_q0 got %0d want 8192", out_prob2[0]); end
    tests_run++;
    if (!(out_prob2[1] >= 16'd4094 && out_prob2[1] <= 16'd4096)) begin
      tests_failed++; $display("FAIL phase_q1 got %0d want 4095 +/-1", out_prob2[1]);
    end
`endif
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    vre = '{16384, 16384, 16384, 16384}; vim = '{0, 0, 0, 0}; vlast = '{0, 0, 0, 1};
    send_frame(0, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL overflow_latency got %0d want 3", lat); end
    tests_run++;
    if (out_prob1 !== {16'd32767, 16'd32767}) begin tests_failed++; $display("FAIL overflow_p1 got %h want 7fff7fff", out_prob1); end
`ifdef MARG2_EN
    tests_run++;
    if (out_prob2 !== {16'd32767, 16'd32767}) begin tests_failed++; $display("FAIL overflow_p2 got %h want 7fff7fff", out_prob2); end
`endif
    tests_run++;
    if (out_ovr !== 1'b1) begin tests_failed++; $display("FAIL overflow_ovr got %b want 1", out_ovr); end
    tests_run++;
    if (out_err !== 1'b0) begin tests_failed++; $display("FAIL overflow_err got %b want 0", out_err); end
    consume();
  endtask

  task automatic test_last_err();
    int lat;
    // Early in_last: frame must still close on beat 3.
    vre = '{8192, 8192, 8192, 8192}; vim = '{0, 0, 0, 0}; vlast = '{0, 1, 0, 1};
    send_frame(0, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL early_last_latency got %0d want 3", lat); end
    tests_run++;
    if (out_prob1 !== {16'd8192, 16'd8192}) begin tests_failed++; $display("FAIL early_last_p1 got %h want 20002000", out_prob1); end
    tests_run++;
    if (out_err !== 1'b1) begin tests_failed++; $display("FAIL early_last_err got %b want 1", out_err); end
    tests_run++;
    if (out_ovr !== 1'b0) begin tests_failed++; $display("FAIL early_last_ovr got %b want 0", out_ovr); end
    consume();
    // Missing in_last on the final beat.
    vlast = '{0, 0, 0, 0};
    send_frame(0, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL missing_last_latency got %0d want 3", lat); end
    tests_run++;
    if (out_err !== 1'b1) begin tests_failed++; $display("FAIL missing_last_err got %b want 1", out_err); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    vre = '{8192, 8192, 8192, 8192}; vim = '{0, 0, 0, 0}; vlast = '{0, 0, 0, 1};
    send_frame(0, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL bp_latency got %0d want 3", lat); end
    // Next frame's first beat is offered while the result is held.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_re = 16'd16384; in_im = 16'd0; in_last = 1'b0;
      tests_run++;
      if (out_prob1 !== {16'd8192, 16'd8192}) begin tests_failed++; $display("FAIL bp_hold_p1 cycle %0d got %h want 20002000", c, out_prob1); end
      tests_run++;
      if ({out_valid, in_ready} !== 2'b10) begin tests_failed++; $display("FAIL bp_hold_hs cycle %0d got valid/ready %b want 10", c, {out_valid, in_ready}); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin tests_failed++; $display("FAIL bp_after_hs got valid/ready %b want 01", {out_valid, in_ready}); end
    @(posedge clk);
    vre = '{16384, 0, 0, 0}; vim = '{0, 0, 0, 0}; vlast = '{0, 0, 0, 1};
    send_frame(1, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL bp_next_latency got %0d want 3", lat); end
    tests_run++;
    if (out_prob1 !== {16'd0, 16'd16384}) begin tests_failed++; $display("FAIL bp_next_p1 got %h want 00004000", out_prob1); end
    tests_run++;
    if (out_err !== 1'b0) begin tests_failed++; $display("FAIL bp_next_err got %b want 0", out_err); end
    consume();
  endtask

  task automatic test_midframe_reset();
    int lat;
    vre = '{16384, 16384, 0, 0}; vim = '{0, 0, 0, 0}; vlast = '{0, 0, 0, 1};
    send_frame(0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_in_ready got %b want 0", in_ready); end
    vre = '{0, 0, 0, 16384};
    send_frame(0, 3);
    wait_result(lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL midreset_latency got %0d want 3", lat); end
    tests_run++;
    if (out_prob1 !== {16'd16384, 16'd0}) begin tests_failed++; $display("FAIL midreset_p1 got %h want 40000000", out_prob1); end
    tests_run++;
    if ({out_ovr, out_err} !== 2'b00) begin tests_failed++; $display("FAIL midreset_flags got %b want 00", {out_ovr, out_err}); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basis00();
    test_uniform();
    test_phase();
    test_overflow();
    test_last_err();
    test_backpressure();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, tests_run %0d", tests_run);
    $fatal(1);
  end

endmodule
